// File: rtl/canny_sched_pkg.sv
// Shared types and helpers for the two-source canny frame scheduler.
package canny_sched_pkg;

   localparam int unsigned SRC_NUM = 2;

   typedef logic [1:0] sched_state_t;

   localparam sched_state_t ST_IDLE   = 2'd0;
   localparam sched_state_t ST_STREAM = 2'd1;
   localparam sched_state_t ST_DRAIN  = 2'd2;

   // Pick the granted source id from the candidate mask; a tie goes to the
   // source that did not win last time.
   function automatic logic rr_pick(input logic [SRC_NUM-1:0] cand, input logic last_grant);
      if (cand == 2'b11) begin
         return ~last_grant;
      end
      return cand[1];
   endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Single-register rise/fall detector for a vsync-style level signal.
// Edges are reported combinationally in the same cycle the input changes.
module vsync_edge_det (
   input  logic i_clk,
   input  logic i_vsync,
   output logic o_rise,
   output logic o_fall
);

   logic r_vsync_d;

   // Delayed copy; deliberately not reset so a source already mid-frame
   // when reset releases does not look like a fresh frame start.
   always_ff @(posedge i_clk) begin
      r_vsync_d <= i_vsync;
   end

   assign o_rise = i_vsync & ~r_vsync_d;
   assign o_fall = ~i_vsync & r_vsync_d;

endmodule

// File: rtl/canny_frame_scheduler.sv
// Frame-granular arbiter sharing one gaussian+canny pipeline between two
// camera streams. One whole frame is granted at a time; the next grant waits
// until the frame has left the pipeline (returned vsync fall) or a timeout.
module canny_frame_scheduler
   import canny_sched_pkg::*;
#(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned DRAIN_TIMEOUT = 4096,
   parameter int unsigned CNT_W         = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SRC_NUM-1:0] src_en,
   input  logic               s0_vsync,
   input  logic               s0_href,
   input  logic               s0_clken,
   input  logic [DATA_W-1:0]  s0_y,
   input  logic               s1_vsync,
   input  logic               s1_href,
   input  logic               s1_clken,
   input  logic [DATA_W-1:0]  s1_y,
   output logic               m_vsync,
   output logic               m_href,
   output logic               m_clken,
   output logic [DATA_W-1:0]  m_y,
   input  logic               ret_vsync,
   output logic               frame_src,
   output logic               busy,
   output logic [CNT_W-1:0]   drop_cnt0,
   output logic [CNT_W-1:0]   drop_cnt1
);

   localparam logic [15:0] TO_LAST = 16'(DRAIN_TIMEOUT - 1);

   sched_state_t        r_state;
   sched_state_t        w_state_d;
   logic [15:0]         r_to_cnt;
   logic [15:0]         w_to_cnt_d;
   logic                r_busy;
   logic                r_sel;
   logic                r_last_grant;
   logic                r_m_vsync;
   logic                r_m_href;
   logic                r_m_clken;
   logic [DATA_W-1:0]   r_m_y;
   logic [CNT_W-1:0]    r_drop_cnt0;
   logic [CNT_W-1:0]    r_drop_cnt1;

   logic                w_s0_rise;
   logic                w_s0_fall;
   logic                w_s1_rise;
   logic                w_s1_fall;
   logic                w_ret_fall;
   logic                w_unused_ret_rise;
   logic [SRC_NUM-1:0]  w_rise_en;
   logic                w_grant;
   logic                w_grant_id;
   logic                w_fwd_id;
   logic                w_fwd_en;
   logic                w_sel_fall;
   logic                w_drop0;
   logic                w_drop1;

   vsync_edge_det u_s0_edge (
      .i_clk   (clk),
      .i_vsync (s0_vsync),
      .o_rise  (w_s0_rise),
      .o_fall  (w_s0_fall)
   );

   vsync_edge_det u_s1_edge (
      .i_clk   (clk),
      .i_vsync (s1_vsync),
      .o_rise  (w_s1_rise),
      .o_fall  (w_s1_fall)
   );

   vsync_edge_det u_ret_edge (
      .i_clk   (clk),
      .i_vsync (ret_vsync),
      .o_rise  (w_unused_ret_rise),
      .o_fall  (w_ret_fall)
   );

   // Grant decision, forwarding select and drop detection.
   always_comb begin
      w_rise_en  = {w_s1_rise & src_en[1], w_s0_rise & src_en[0]};
      w_grant    = (r_state == ST_IDLE) && (w_rise_en != '0);
      w_grant_id = rr_pick(w_rise_en, r_last_grant);
      // The grant cycle already forwards the rising vsync of the winner.
      w_fwd_id   = w_grant ? w_grant_id : r_sel;
      w_fwd_en   = w_grant || (r_state == ST_STREAM);
      w_sel_fall = r_sel ? w_s1_fall : w_s0_fall;
      w_drop0    = w_rise_en[0] & ~(w_grant & ~w_grant_id);
      w_drop1    = w_rise_en[1] & ~(w_grant & w_grant_id);
   end

   // Next-state logic and drain timeout counter.
   always_comb begin
      w_state_d  = r_state;
      w_to_cnt_d = r_to_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            w_to_cnt_d = '0;
            if (w_sel_fall) begin
               w_state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_ret_fall || (r_to_cnt == TO_LAST)) begin
               w_state_d = ST_IDLE;
            end else begin
               w_to_cnt_d = r_to_cnt + 16'd1;
            end
         end
         default: begin
            w_state_d = ST_IDLE;
         end
      endcase
   end

   // State register; busy is registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_to_cnt <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_to_cnt <= w_to_cnt_d;
         r_busy   <= (w_state_d != ST_IDLE);
      end
   end

   // Selected source and round-robin history, updated only on a grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel        <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_grant) begin
         r_sel        <= w_grant_id;
         r_last_grant <= w_grant_id;
      end
   end

   // Registered 2:1 video mux; zero outside a granted frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_vsync <= 1'b0;
         r_m_href  <= 1'b0;
         r_m_clken <= 1'b0;
         r_m_y     <= '0;
      end else if (w_fwd_en) begin
         r_m_vsync <= w_fwd_id ? s1_vsync : s0_vsync;
         r_m_href  <= w_fwd_id ? s1_href  : s0_href;
         r_m_clken <= w_fwd_id ? s1_clken : s0_clken;
         r_m_y     <= w_fwd_id ? s1_y     : s0_y;
      end else begin
         r_m_vsync <= 1'b0;
         r_m_href  <= 1'b0;
         r_m_clken <= 1'b0;
         r_m_y     <= '0;
      end
   end

   // Saturating per-source dropped-frame counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt0 <= '0;
         r_drop_cnt1 <= '0;
      end else begin
         if (w_drop0 && (r_drop_cnt0 != '1)) begin
            r_drop_cnt0 <= r_drop_cnt0 + CNT_W'(1);
         end
         if (w_drop1 && (r_drop_cnt1 != '1)) begin
            r_drop_cnt1 <= r_drop_cnt1 + CNT_W'(1);
         end
      end
   end

   assign m_vsync   = r_m_vsync;
   assign m_href    = r_m_href;
   assign m_clken   = r_m_clken;
   assign m_y       = r_m_y;
   assign frame_src = r_sel;
   assign busy      = r_busy;
   assign drop_cnt0 = r_drop_cnt0;
   assign drop_cnt1 = r_drop_cnt1;

endmodule

// File: tb/tb_canny_frame_scheduler.sv
// Scoreboard bench for canny_frame_scheduler: frame drivers push expected
// forwarded pixels, a monitor pops them whenever m_clken is high.
module tb_canny_frame_scheduler;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned DRAIN_TO = 16;
   localparam int unsigned CNT_W   = 4;
   localparam int          RET_DLY = 8;

   typedef struct packed {
      logic       src;
      logic [7:0] y;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        src_en = 2'b11;
   logic              s0_vsync = 0, s0_href = 0, s0_clken = 0;
   logic [DATA_W-1:0] s0_y = '0;
   logic              s1_vsync = 0, s1_href = 0, s1_clken = 0;
   logic [DATA_W-1:0] s1_y = '0;
   logic              m_vsync, m_href, m_clken;
   logic [DATA_W-1:0] m_y;
   logic              ret_vsync = 1'b0;
   logic              frame_src, busy;
   logic [CNT_W-1:0]  drop_cnt0, drop_cnt1;

   int                checks = 0;
   int                errors = 0;
   exp_t              q[$];
   exp_t              e;
   logic [RET_DLY-1:0] ret_sh = '0;
   bit                ret_hold0 = 1'b0;
   logic              prev_busy;
   int                n;

   canny_frame_scheduler #(
      .DATA_W        (DATA_W),
      .DRAIN_TIMEOUT (DRAIN_TO),
      .CNT_W         (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .src_en    (src_en),
      .s0_vsync  (s0_vsync),
      .s0_href   (s0_href),
      .s0_clken  (s0_clken),
      .s0_y      (s0_y),
      .s1_vsync  (s1_vsync),
      .s1_href   (s1_href),
      .s1_clken  (s1_clken),
      .s1_y      (s1_y),
      .m_vsync   (m_vsync),
      .m_href    (m_href),
      .m_clken   (m_clken),
      .m_y       (m_y),
      .ret_vsync (ret_vsync),
      .frame_src (frame_src),
      .busy      (busy),
      .drop_cnt0 (drop_cnt0),
      .drop_cnt1 (drop_cnt1)
   );

   always #5 clk = ~clk;

   // Pipeline stand-in: ret_vsync is m_vsync delayed, or held low.
   always @(negedge clk) begin
      ret_sh    = {ret_sh[RET_DLY-2:0], m_vsync};
      ret_vsync = ret_hold0 ? 1'b0 : ret_sh[RET_DLY-1];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every forwarded pixel must match the next queued expectation.
   always @(negedge clk) begin
      if (m_clken) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got src %0d y %0h, expected no pixel", frame_src, m_y);
         end else begin
            e = q.pop_front();
            chk("pixel_src", 32'(frame_src), 32'(e.src));
            chk("pixel_y", 32'(m_y), 32'(e.y));
            chk("pixel_href", 32'(m_href), 32'd1);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic drv(input int src, input logic v, input logic h, input logic c,
                      input logic [7:0] y);
      if (src == 0) begin
         s0_vsync = v; s0_href = h; s0_clken = c; s0_y = y;
      end else begin
         s1_vsync = v; s1_href = h; s1_clken = c; s1_y = y;
      end
   endtask

   // One frame: 2 blank cycles, lines of pix pixels + 2 blank, then vsync low.
   // rst_line >= 0 pulses rst at the first pixel of that line.
   task automatic drive_frame(input int src, input int lines, input int pix,
                              input logic [7:0] seed, input bit fwd, input int rst_line);
      bit         push;
      logic [7:0] y;
      push = fwd;
      @(negedge clk);
      drv(src, 1, 0, 0, 8'h00);
      repeat (2) @(negedge clk);
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < pix; p++) begin
            @(negedge clk);
            y = seed + 8'(l * pix + p);
            if (l == rst_line && p == 0) begin
               rst  = 1'b1;
               push = 1'b0;
            end
            if (l == rst_line && p == 1) begin
               rst = 1'b0;
               chk("rst_mid_m_vsync", 32'(m_vsync), 32'd0);
               chk("rst_mid_m_clken", 32'(m_clken), 32'd0);
               chk("rst_mid_busy", 32'(busy), 32'd0);
               chk("rst_mid_drop1", 32'(drop_cnt1), 32'd0);
            end
            drv(src, 1, 1, 1, y);
            if (push) q.push_back(exp_t'{src: src[0], y: y});
         end
         repeat (2) begin
            @(negedge clk);
            drv(src, 1, 0, 0, 8'h00);
         end
      end
      @(negedge clk);
      drv(src, 0, 0, 0, 8'h00);
   endtask

   task automatic tiny_frame(input int src);
      @(negedge clk);
      drv(src, 1, 0, 0, 8'h00);
      repeat (2) @(negedge clk);
      drv(src, 0, 0, 0, 8'h00);
      @(negedge clk);
   endtask

   task automatic frame_and_check(input int src, input int lines, input int pix,
                                  input logic [7:0] seed);
      fork
         drive_frame(src, lines, pix, seed, 1'b1, -1);
         begin
            repeat (6) @(negedge clk);
            chk("grant_src", 32'(frame_src), 32'(src));
            chk("grant_busy", 32'(busy), 32'd1);
            chk("grant_m_vsync", 32'(m_vsync), 32'd1);
         end
      join
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk(name, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      drv(0, 0, 0, 0, 8'h00);
      drv(1, 0, 0, 0, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_m_vsync", 32'(m_vsync), 32'd0);
      chk("reset_m_clken", 32'(m_clken), 32'd0);
      chk("reset_frame_src", 32'(frame_src), 32'd0);
      chk("reset_drop0", 32'(drop_cnt0), 32'd0);
      chk("reset_drop1", 32'(drop_cnt1), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      do_reset();

      // 1: single source, pipeline returns vsync RET_DLY later.
      frame_and_check(0, 4, 8, 8'h10);
      prev_busy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (!ret_vsync) break;
         prev_busy = busy;
      end
      chk("t1_ret_fall_seen", 32'(ret_vsync), 32'd0);
      chk("t1_busy_before_ret_fall", 32'(prev_busy), 32'd1);
      chk("t1_busy_after_ret_fall", 32'(busy), 32'd0);
      wait_idle("t1_idle");

      // 2: simultaneous rises, round-robin.
      do_reset();
      fork
         drive_frame(0, 2, 4, 8'h20, 1'b1, -1);
         drive_frame(1, 2, 4, 8'hA0, 1'b0, -1);
      join
      wait_idle("t2a_idle");
      chk("t2a_src", 32'(frame_src), 32'd0);
      chk("t2a_drop0", 32'(drop_cnt0), 32'd0);
      chk("t2a_drop1", 32'(drop_cnt1), 32'd1);
      fork
         drive_frame(0, 2, 4, 8'h30, 1'b0, -1);
         drive_frame(1, 2, 4, 8'hB0, 1'b1, -1);
      join
      wait_idle("t2b_idle");
      chk("t2b_src", 32'(frame_src), 32'd1);
      chk("t2b_drop0", 32'(drop_cnt0), 32'd1);
      chk("t2b_drop1", 32'(drop_cnt1), 32'd1);

      // 3: s1 rises during s0 stream, then gets the next grant.
      do_reset();
      fork
         drive_frame(0, 4, 8, 8'h40, 1'b1, -1);
         begin
            repeat (10) @(negedge clk);
            tiny_frame(1);
         end
      join
      wait_idle("t3a_idle");
      chk("t3_drop1", 32'(drop_cnt1), 32'd1);
      chk("t3_drop0", 32'(drop_cnt0), 32'd0);
      frame_and_check(1, 2, 4, 8'hC0);
      wait_idle("t3b_idle");

      // 4: ret_vsync stuck low, drain ends on timeout.
      do_reset();
      ret_hold0 = 1'b1;
      frame_and_check(0, 2, 4, 8'h50);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (busy) n++;
         else break;
      end
      chk("t4_drain_cycles", 32'(n), 32'(DRAIN_TO));
      repeat (2) @(negedge clk);
      frame_and_check(1, 2, 4, 8'hD0);
      wait_idle("t4_idle");
      ret_hold0 = 1'b0;
      repeat (10) @(negedge clk);

      // 5: reset mid-frame; the rest of that frame must not be granted.
      do_reset();
      fork
         drive_frame(0, 4, 8, 8'h60, 1'b1, 2);
         begin
            repeat (5) @(negedge clk);
            tiny_frame(1);
         end
      join
      repeat (2) @(negedge clk);
      chk("t5_not_regranted", 32'(busy), 32'd0);
      frame_and_check(0, 2, 4, 8'h70);
      wait_idle("t5_idle");

      // 6: only s1 enabled.
      do_reset();
      src_en = 2'b10;
      fork
         drive_frame(0, 2, 4, 8'h80, 1'b0, -1);
         frame_and_check(1, 2, 4, 8'hE0);
      join
      wait_idle("t6a_idle");
      fork
         drive_frame(0, 2, 4, 8'h88, 1'b0, -1);
         begin
            repeat (3) @(negedge clk);
            frame_and_check(1, 2, 4, 8'hE8);
         end
      join
      wait_idle("t6b_idle");
      chk("t6_drop0", 32'(drop_cnt0), 32'd0);
      chk("t6_drop1", 32'(drop_cnt1), 32'd0);

      // Saturation: 17 s1 rises while s0 streams, 4-bit counter stops at 15.
      do_reset();
      src_en = 2'b11;
      fork
         drive_frame(0, 8, 8, 8'h90, 1'b1, -1);
         begin
            repeat (3) @(negedge clk);
            for (int i = 0; i < 17; i++) begin
               tiny_frame(1);
               if (i == 13) chk("sat_mid_drop1", 32'(drop_cnt1), 32'd14);
            end
         end
      join
      wait_idle("sat_idle");
      chk("sat_final_drop1", 32'(drop_cnt1), 32'd15);
      chk("sat_drop0", 32'(drop_cnt0), 32'd0);

      repeat (5) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
